// File: rtl/pet_need_scheduler.sv
// Need-level sequencer for the pet: owns the four 2-bit need levels, a tick
// prescaler and a round-robin decay slot. It arbitrates user restore requests
// (edge-type feed/medicine, hold-type affection/sleep) against decay.
module pet_need_scheduler #(
  parameter int TICK_DIV   = 6250000,
  parameter int SLOT_TICKS = 60,
  parameter int HOLD_TICKS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       test,
  input  logic       comida,
  input  logic       medicina,
  input  logic       carino,
  input  logic       dormir,
  output logic [1:0] level_animo,
  output logic [1:0] level_hambre,
  output logic [1:0] level_sueno,
  output logic [1:0] level_salud,
  output logic       led_animo,
  output logic       led_hambre,
  output logic       led_sueno,
  output logic       led_salud,
  output logic [1:0] slot,
  output logic       tick,
  output logic       critical
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Need index order: 0=animo, 1=hambre, 2=sueno, 3=salud (matches slot).
  state_t            r_state;
  state_t            w_state_next;
  logic              w_run;
  logic [PW-1:0]     r_presc;
  logic              r_tick;
  logic              w_tick;
  logic [SW-1:0]     r_scnt;
  logic [1:0]        r_slot;
  logic              w_slot_end;
  logic [HW-1:0]     r_hold_pet;
  logic [HW-1:0]     r_hold_sleep;
  logic              r_comida_d;
  logic              r_med_d;
  logic [3:0][1:0]   r_lvl;
  logic [3:0]        w_inc;
  logic [3:0]        w_dec;
  logic [3:0]        r_led;
  logic              r_crit;

  // Saturating level update; a simultaneous restore and decay cancel out.
  function automatic logic [1:0] next_level(input logic [1:0] lvl,
                                            input logic inc, input logic dec);
    logic [1:0] res;
    res = lvl;
    if (inc && !dec && (lvl != 2'd3))
      res = lvl + 2'd1;
    else if (dec && !inc && (lvl != 2'd0))
      res = lvl - 2'd1;
    return res;
  endfunction

  // Tick source: prescaler wrap, or every cycle while accelerated.
  assign w_tick = test | (r_presc == PRESC_LAST);

  // Prescaler and registered tick pulse; held at 0 in accelerate mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_tick  <= w_tick;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state: the first tick starts the run; only reset leaves RUN.
  always_comb begin
    w_state_next = r_state;
    if ((r_state == IDLE) && w_tick) w_state_next = RUN;
  end

  // FSM outputs: decay and restores are gated by RUN.
  always_comb begin
    w_run = (r_state == RUN);
  end

  // Event decode for this cycle: slot decay plus the four restore sources.
  always_comb begin
    w_slot_end = w_run && w_tick && (r_scnt == SLOT_LAST);
    w_dec      = w_slot_end ? (4'b0001 << r_slot) : 4'b0000;
    w_inc[0]   = w_run && w_tick && carino && (r_hold_pet == HOLD_LAST);
    w_inc[1]   = w_run && comida && !r_comida_d;
    w_inc[2]   = w_run && w_tick && dormir && (r_hold_sleep == HOLD_LAST);
    w_inc[3]   = w_run && medicina && !r_med_d;
  end

  // Slot-tick counter and round-robin slot pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scnt <= '0;
      r_slot <= 2'd0;
    end else if (w_run && w_tick) begin
      if (w_slot_end) begin
        r_scnt <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_scnt <= r_scnt + SW'(1);
      end
    end
  end

  // Hold counters: count ticks while held in RUN, clear as soon as released.
  always_ff @(posedge clk) begin
    if (reset || !w_run || !carino)
      r_hold_pet <= '0;
    else if (w_tick)
      r_hold_pet <= (r_hold_pet == HOLD_LAST) ? '0 : r_hold_pet + HW'(1);
    if (reset || !w_run || !dormir)
      r_hold_sleep <= '0;
    else if (w_tick)
      r_hold_sleep <= (r_hold_sleep == HOLD_LAST) ? '0 : r_hold_sleep + HW'(1);
  end

  // Previous-cycle copies of the edge-type requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_comida_d <= 1'b0;
      r_med_d    <= 1'b0;
    end else begin
      r_comida_d <= comida;
      r_med_d    <= medicina;
    end
  end

  // Need level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lvl <= '1;
    end else begin
      for (int i = 0; i < 4; i++)
        r_lvl[i] <= next_level(r_lvl[i], w_inc[i], w_dec[i]);
    end
  end

  // LEDs and critical flag, registered one cycle behind the levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led  <= 4'b0000;
      r_crit <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        r_led[i] <= (r_lvl[i] != 2'd3);
      r_crit <= (r_lvl[0] == 2'd0) || (r_lvl[1] == 2'd0) ||
                (r_lvl[2] == 2'd0) || (r_lvl[3] == 2'd0);
    end
  end

  assign level_animo  = r_lvl[0];
  assign level_hambre = r_lvl[1];
  assign level_sueno  = r_lvl[2];
  assign level_salud  = r_lvl[3];
  assign led_animo    = r_led[0];
  assign led_hambre   = r_led[1];
  assign led_sueno    = r_led[2];
  assign led_salud    = r_led[3];
  assign slot         = r_slot;
  assign tick         = r_tick;
  assign critical     = r_crit;

endmodule
